boid_update_sequencer: RTL
==========================

// Module: boid_update_sequencer
// PURPOSE
//  Per-frame scheduler for the boid state register memory. On frame_start it walks boids
//  0..NUM_BOIDS-1: selects boid i, snapshots its x/y/vx/vy into the update datapath,
//  launches it via req/ack, waits for done, then writes results back with a wb_en mask.
//  Also shares the memory port with a host (HPS) writer, granted only between boids.
// PARAMETERS
//  NUM_BOIDS   2    boids per frame; >=1
//  IDX_W       $clog2(NUM_BOIDS)+1   which_boid width, matches memory select port
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high
//  frame_start  in   1      1-cycle pulse: begin one update pass
//  busy         out  1      high from accepted frame_start until frame_done
//  frame_done   out  1      1-cycle pulse after last boid written back
//  which_boid   out  IDX_W  memory select (sequencer index, or host_idx when host granted)
//  wb_en        out  7      memory write enables: [0] global, [1]x [2]y [3]vx [4]vy [5]vx_acc [6]vy_acc
//  xcel_load    out  1      1-cycle pulse: datapath captures memory outputs for which_boid
//  xcel_req     out  1      level; held until xcel_ack
//  xcel_ack     in   1      datapath accepted request
//  xcel_done    in   1      1-cycle pulse: results valid on datapath outputs
//  host_req     in   1      level; host wants the memory port
//  host_idx     in   IDX_W  boid the host targets
//  host_wmask   in   6      host field enables -> wb_en[6:1]
//  host_gnt     out  1      host owns port this cycle; host write lands when host_gnt & host_req
// BEHAVIOUR
//  Reset: state IDLE, idx=0; busy, frame_done, xcel_load, xcel_req, host_gnt = 0;
//   wb_en = 7'b0; which_boid = 0. Reset mid-frame aborts with no write-back; no frame_done.
//  States: IDLE, LOAD, ISSUE, WAIT, WRITE, NEXT, HOST.
//  IDLE: host_req -> HOST (host has priority over a simultaneous frame_start; start is
//   dropped). Else frame_start -> LOAD, idx<=0, busy<=1.
//  LOAD (1 cyc): which_boid=idx, xcel_load=1 -> ISSUE.
//  ISSUE: xcel_req=1 until xcel_ack; on ack -> WAIT. xcel_done sampled only in WAIT.
//  WAIT: which_boid=idx held; on xcel_done -> WRITE. No timeout.
//  WRITE (1 cyc): wb_en=7'b111_1111, which_boid=idx -> NEXT.
//  NEXT: idx==NUM_BOIDS-1 -> frame_done=1, busy<=0, IDLE (or HOST if host_req, same cycle);
//   else idx<=idx+1; host_req -> HOST (resume LOAD after), else LOAD.
//  HOST: host_gnt=1, which_boid=host_idx, wb_en={host_wmask, host_req}; stays while
//   host_req; on host_req=0 -> LOAD if busy, else IDLE. busy stays high during mid-frame HOST.
//  frame_start while busy: ignored, no queuing.
//  wb_en is 0 in every state except WRITE and HOST; never two writes to same boid per pass.
//  Min per-boid latency, ack same cycle as req, done 1 cyc later: LOAD..NEXT = 5 cycles;
//   frame of N boids: 5N cycles from frame_start to frame_done (frame_done in last NEXT).
//  idx never exceeds NUM_BOIDS-1; no wrap.
// STRUCTURE
//  Shared package boid_pkg: state enum seq_state_t, WB_ALL=7'b1111111, WB_GLOBAL bit index,
//   field-bit localparams (WB_X..WB_VYA). Single module, no sub-modules; outputs registered
//   except which_boid/wb_en, which are decoded from state.
// TESTING
//  NUM_BOIDS=2, ack/done immediate: frame_start -> wb_en=7F at idx 0 then 1, frame_done @ +10.
//  Hold xcel_ack low 3 cycles in ISSUE -> xcel_req stays 1, wb_en stays 0, frame_done @ +13.
//  host_req asserted during boid 0 WAIT -> host_gnt only after boid 0 WRITE; boid 1 LOAD
//   follows host_req drop; frame_done still fires once.
//  frame_start + host_req same cycle in IDLE -> HOST granted, start dropped, busy stays 0.
//  reset during WAIT of boid 1 -> next cycle all outputs 0, no wb_en, no frame_done.
//  frame_start pulses while busy -> exactly one frame_done per accepted start.

Source files
------------

// File: rtl/boid_pkg.sv
// Shared types and write-enable bit positions for the boid state memory sequencer.
package boid_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_HOST
    } seq_state_t;

    // wb_en bit map: [0] global strobe, [6:1] per-field enables
    localparam int WB_GLOBAL = 0;
    localparam int WB_X      = 1;
    localparam int WB_Y      = 2;
    localparam int WB_VX     = 3;
    localparam int WB_VY     = 4;
    localparam int WB_VXA    = 5;
    localparam int WB_VYA    = 6;

    localparam logic [6:0] WB_ALL = 7'b111_1111;

endpackage

// File: rtl/boid_update_sequencer.sv
// Per-frame boid update scheduler: walks every boid through load/issue/wait/write
// and lends the memory port to the host only between boids.
module boid_update_sequencer
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS = 2,
    parameter int IDX_W     = $clog2(NUM_BOIDS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    output logic             busy,
    output logic             frame_done,
    output logic [IDX_W-1:0] which_boid,
    output logic [6:0]       wb_en,
    output logic             xcel_load,
    output logic             xcel_req,
    input  logic             xcel_ack,
    input  logic             xcel_done,
    input  logic             host_req,
    input  logic [IDX_W-1:0] host_idx,
    input  logic [5:0]       host_wmask,
    output logic             host_gnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOIDS - 1);

    seq_state_t       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             xcel_load_q;
    logic             xcel_req_q;
    logic             host_gnt_q;
    logic             last_boid;

    assign last_boid = (idx_q == LAST_IDX);

    // Pulse outputs default low each cycle and are raised on entry to their state,
    // so they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            xcel_load_q  <= 1'b0;
            xcel_req_q   <= 1'b0;
            host_gnt_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            xcel_load_q  <= 1'b0;
            host_gnt_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host_req) begin
                        state_q    <= S_HOST;
                        host_gnt_q <= 1'b1;
                    end else if (frame_start) begin
                        state_q     <= S_LOAD;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        xcel_load_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q    <= S_ISSUE;
                    xcel_req_q <= 1'b1;
                end
                S_ISSUE: begin
                    if (xcel_ack) begin
                        state_q    <= S_WAIT;
                        xcel_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (xcel_done) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_q      <= S_NEXT;
                    frame_done_q <= last_boid;
                end
                S_NEXT: begin
                    if (last_boid) begin
                        busy_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                    if (host_req) begin
                        state_q    <= S_HOST;
                        host_gnt_q <= 1'b1;
                    end else if (last_boid) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q     <= S_LOAD;
                        xcel_load_q <= 1'b1;
                    end
                end
                S_HOST: begin
                    // busy_q remembers whether a frame is still pending behind the host
                    if (host_req) begin
                        host_gnt_q <= 1'b1;
                    end else if (busy_q) begin
                        state_q     <= S_LOAD;
                        xcel_load_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        which_boid = idx_q;
        wb_en      = '0;
        case (state_q)
            S_WRITE: begin
                wb_en = WB_ALL;
            end
            S_HOST: begin
                which_boid          = host_idx;
                wb_en[WB_GLOBAL]    = host_req;
                wb_en[WB_VYA:WB_X]  = host_wmask;
            end
            default: begin
                wb_en = '0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign xcel_load  = xcel_load_q;
    assign xcel_req   = xcel_req_q;
    assign host_gnt   = host_gnt_q;

endmodule
